seg_shift_ctrl: RTL
===================

// Module: seg_shift_ctrl
// PURPOSE
//  Sequencer for the serial 7-seg/LED shift-register chain. Snapshots a 32-bit
//  display word and steps the 3-bit scan index through the 4 byte phases. The
//  external segment-bit mapper returns one 8-bit pattern per phase. Each byte is
//  shifted out MSB first on sclk/sdata, then the chain is latched with sload.
//  Sits between the display register and the board shift-register pins.
// PARAMETERS
//  CLK_DIV    4       clk cycles per sclk half-period; legal range 1..255
//  NUM_BYTES  4       byte phases per frame (scan values 0..NUM_BYTES-1); legal range 1..4
//  REFRESH    50000   clk cycles between auto frames (only with SEG_AUTO_REFRESH_EN)
// PORTS
//  clk       in   1   system clock
//  rst_n     in   1   asynchronous active-low reset
//  start     in   1   request frame; accepted only when busy==0
//  hexs      in   32  display word; sampled on the accepted start
//  seg_byte  in   8   mapper output for current scan; valid same cycle (comb)
//  hexs_q    out  32  captured word; drives the mapper's Hexs input
//  scan      out  3   byte phase index to mapper; bit 2 always 0
//  sclk      out  1   shift clock; chain samples sdata on rising edge
//  sdata     out  1   serial data
//  sload     out  1   latch pulse, high for CLK_DIV cycles after last bit
//  busy      out  1   frame in progress
//  done      out  1   one-cycle pulse when frame latched
// BEHAVIOUR
//  Reset values: hexs_q=0, scan=0, sclk=0, sdata=0, sload=0, busy=0, done=0.
//  Reset is asynchronous and active-low: all outputs take reset values
//  immediately, with no partial latch.
//  FSM: IDLE -> LOAD -> LOW -> HIGH -> (LOW | LOAD | LATCH) -> DONE -> IDLE.
//   IDLE: sclk=0. start=1 -> capture hexs into hexs_q; scan=NUM_BYTES-1;
//         busy=1 next cycle.
//   LOAD: copy seg_byte into 8-bit shift reg; bit_cnt=7 (1 cycle).
//   LOW : sclk=0; sdata=shreg[7]; hold CLK_DIV cycles.
//   HIGH: sclk=1 for CLK_DIV cycles, then shift shreg left.
//         bit_cnt!=0 -> decrement bit_cnt, go to LOW.
//         bit_cnt==0 and scan!=0 -> decrement scan, go to LOAD.
//         bit_cnt==0 and scan==0 -> go to LATCH.
//   LATCH: sclk=0, sload=1 for CLK_DIV cycles.
//   DONE: done=1 for 1 cycle, busy=0 -> IDLE.
//  Byte order is scan 3,2,1,0; scan 0 byte ends nearest the chain input.
//  Frame latency, start accept to done: 2 + NUM_BYTES*(1+16*CLK_DIV) + CLK_DIV
//  cycles. With defaults: 2 + 4*(1+64) + 4 = 266.
//  Boundary conditions:
//   start while busy -> ignored, not queued.
//   start and reset deassert in the same cycle -> start ignored.
//   hexs changes mid-frame -> no effect (hexs_q frozen).
//   CLK_DIV counter is 8 bits, reloaded at each state entry; no wrap.
// CONFIGURATION
//  `SEG_AUTO_REFRESH_EN defined:
//   - A 32-bit counter runs in IDLE.
//   - At REFRESH cycles it self-starts a frame, sampling hexs as for start.
//   - Any frame start clears the counter; start has priority in the same cycle.
//  Undefined: frames start only on start; no counter logic is synthesised.
// STRUCTURE
//  Package seg_pkg:
//   - state enum (IDLE, LOAD, LOW, HIGH, LATCH, DONE)
//   - SEG_BYTE_W=8
//   - SCAN_W=3
//  One sub-module, seg_clk_div: CLK_DIV half-period counter with reload and
//  tick output, instanced once. FSM, shift register and refresh counter are
//  in this module.
// TESTING
//  1. Reset: hold rst_n=0 -> all outputs 0. Assert rst_n=0 mid-frame -> sload
//     never pulses, busy=0 immediately.
//  2. Pattern: CLK_DIV=1, seg_byte forced A5,3C,0F,81 for scan 3..0.
//     - Sampled stream = 1010_0101 0011_1100 0000_1111 1000_0001.
//     - 32 sclk rises.
//     - Then sload high 1 cycle, then done.
//  3. Latency: default params, start at t0 -> done at t0+266; busy high
//     t0+1..t0+265.
//  4. Collision: start re-pulsed at cycle 50 of a frame -> exactly one done;
//     hexs_q unchanged.
//  5. Capture: hexs=DEADBEEF at start, then 0 next cycle -> hexs_q=DEADBEEF
//     until the next accepted start.
//  6. `SEG_AUTO_REFRESH_EN, REFRESH=100, no start -> frames start every
//     100+latency cycles. A start at idle cycle 40 -> counter restarts from 0.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared types and widths for the serial 7-seg/LED shift-chain sequencer.
package seg_pkg;
    localparam int SEG_BYTE_W = 8;
    localparam int SCAN_W     = 3;
    localparam int HEXS_W     = 32;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        LOW,
        HIGH,
        LATCH,
        DONE
    } seg_state_e;
endpackage

// File: rtl/seg_shift_ctrl_if.sv
// Host/mapper/pin bundle of seg_shift_ctrl; the sequencer uses the slave side.
interface seg_shift_ctrl_if;
    import seg_pkg::*;

    logic                  start;
    logic [HEXS_W-1:0]     hexs;
    logic [SEG_BYTE_W-1:0] seg_byte;
    logic [HEXS_W-1:0]     hexs_q;
    logic [SCAN_W-1:0]     scan;
    logic                  sclk;
    logic                  sdata;
    logic                  sload;
    logic                  busy;
    logic                  done;

    modport master (
        output start, hexs, seg_byte,
        input  hexs_q, scan, sclk, sdata, sload, busy, done
    );

    modport slave (
        input  start, hexs, seg_byte,
        output hexs_q, scan, sclk, sdata, sload, busy, done
    );
endinterface

// File: rtl/seg_clk_div.sv
// Half-period timer: reload starts a CLK_DIV-cycle interval, tick marks its last cycle.
module seg_clk_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic reload,
    output logic tick
);
    localparam logic [7:0] RELOAD_VAL = 8'(CLK_DIV - 1);

    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (reload) begin
            cnt_d = RELOAD_VAL;
        end else if (cnt_q != 8'd0) begin
            cnt_d = cnt_q - 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Counter parks at zero, so an interval never wraps past its end.
    assign tick = (cnt_q == 8'd0);
endmodule

// File: rtl/seg_shift_ctrl.sv
// Frame sequencer for the serial 7-seg shift chain: byte phases MSB-first, then latch.
// Optional `SEG_AUTO_REFRESH_EN adds a self-starting refresh timer in IDLE.
module seg_shift_ctrl
    import seg_pkg::*;
#(
    parameter int CLK_DIV   = 4,
    parameter int NUM_BYTES = 4,
    parameter int REFRESH   = 50000
) (
    input  logic             clk,
    input  logic             rst_n,
    seg_shift_ctrl_if.slave  bus
);
    if (CLK_DIV < 1 || CLK_DIV > 255 || NUM_BYTES < 1 || NUM_BYTES > 4 || REFRESH < 1) begin : g_bad_param
        $error("seg_shift_ctrl: parameter out of legal range");
    end

    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(NUM_BYTES - 1);

    seg_state_e            state_q, state_d;
    logic [SEG_BYTE_W-1:0] shreg_q, shreg_d;
    logic [2:0]            bit_cnt_q, bit_cnt_d;
    logic [SCAN_W-1:0]     scan_q, scan_d;
    logic [HEXS_W-1:0]     hexs_q, hexs_d;
    logic                  sclk_q, sclk_d;
    logic                  sdata_q, sdata_d;
    logic                  sload_q, sload_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  armed_q, armed_d;
    logic                  tick;
    logic                  frame_start;
    logic                  auto_start;

    // Every state entry restarts the half-period timer.
    seg_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
        .clk    (clk),
        .rst_n  (rst_n),
        .reload (state_d != state_q),
        .tick   (tick)
    );

    // armed_q blocks a start seen on the first edge after reset release.
    assign armed_d     = 1'b1;
    assign frame_start = armed_q && (state_q == IDLE) && (bus.start || auto_start);

`ifdef SEG_AUTO_REFRESH_EN
    logic [31:0] refresh_q, refresh_d;

    assign auto_start = (refresh_q == 32'(REFRESH - 1));

    always_comb begin
        refresh_d = 32'd0;
        if ((state_q == IDLE) && !frame_start) begin
            refresh_d = refresh_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            refresh_q <= 32'd0;
        end else begin
            refresh_q <= refresh_d;
        end
    end
`else
    assign auto_start = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        scan_d    = scan_q;
        hexs_d    = hexs_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (frame_start) begin
                    hexs_d  = bus.hexs;
                    scan_d  = SCAN_LAST;
                    busy_d  = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                shreg_d   = bus.seg_byte;
                bit_cnt_d = 3'd7;
                state_d   = LOW;
            end
            LOW: begin
                if (tick) state_d = HIGH;
            end
            HIGH: begin
                if (tick) begin
                    shreg_d = {shreg_q[SEG_BYTE_W-2:0], 1'b0};
                    if (bit_cnt_q != 3'd0) begin
                        bit_cnt_d = bit_cnt_q - 3'd1;
                        state_d   = LOW;
                    end else if (scan_q != '0) begin
                        scan_d  = scan_q - SCAN_W'(1);
                        state_d = LOAD;
                    end else begin
                        state_d = LATCH;
                    end
                end
            end
            LATCH: begin
                if (tick) state_d = DONE;
            end
            DONE: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Pin outputs are registered from the next state so they line up with it.
        sclk_d  = (state_d == HIGH);
        sload_d = (state_d == LATCH);
        sdata_d = 1'b0;
        if (state_d == LOW) begin
            sdata_d = shreg_d[SEG_BYTE_W-1];
        end else if (state_d == HIGH) begin
            sdata_d = sdata_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= 3'd0;
            scan_q    <= '0;
            hexs_q    <= '0;
            sclk_q    <= 1'b0;
            sdata_q   <= 1'b0;
            sload_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            armed_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            scan_q    <= scan_d;
            hexs_q    <= hexs_d;
            sclk_q    <= sclk_d;
            sdata_q   <= sdata_d;
            sload_q   <= sload_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            armed_q   <= armed_d;
        end
    end

    assign bus.hexs_q = hexs_q;
    assign bus.scan   = scan_q;
    assign bus.sclk   = sclk_q;
    assign bus.sdata  = sdata_q;
    assign bus.sload  = sload_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
endmodule
